divider_n: RTL

Multi-channel programmable clock divider and enable generator. It is the parametrised successor of the single fixed-N toggle divider. Each channel divides the system clock by a run-time-loadable half-period, in either 50%-duty toggle mode or single-cycle pulse mode. Divisor loads use a valid/ready handshake and take effect glitch-free at the next period boundary. The block feeds display scan, debounce and slow-tick logic.

---
 rtl/divider_n_pkg.sv | 17 +
 rtl/divider_n_if.sv | 30 +++
 rtl/divider_n_ch.sv | 80 ++++++++
 rtl/divider_n.sv | 59 +++++
 4 files changed

// File: rtl/divider_n_pkg.sv
// Shared constants and helpers for the divider_n multi-channel clock divider.
// Optional phase-align input is enabled by defining DIVN_SYNC_EN.
package divider_n_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Reset half-period of every channel: one second ticks at 100 MHz.
    localparam int unsigned DIVN_DEF_HALF = 100_000_000;

    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/divider_n_if.sv
// Divisor load handshake bundle for divider_n (valid/ready with channel select).
// Optional phase-align input on the top is enabled by defining DIVN_SYNC_EN.
interface divider_n_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 32
);
    import divider_n_pkg::*;

    localparam int CHW = ch_idx_w(CH);

    logic             ld_valid;
    logic [CHW-1:0]   ld_ch;
    logic [CNT_W-1:0] ld_half;
    logic             ld_ready;

    modport master (
        output ld_valid,
        output ld_ch,
        output ld_half,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_ch,
        input  ld_half,
        output ld_ready
    );

endinterface

// File: rtl/divider_n_ch.sv
// One divider channel: counter, active/shadow half-period, clk_n and tick.
// With DIVN_SYNC_EN defined, a sync input realigns the channel phase.
module divider_n_ch
    import divider_n_pkg::*;
#(
    parameter int               CNT_W    = 32,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DIVN_DEF_HALF)
) (
    input  logic             click,
    input  logic             reset,
`ifdef DIVN_SYNC_EN
    input  logic             sync,
`endif
    input  logic             en,
    input  logic             mode,
    input  logic             ld_we,
    input  logic [CNT_W-1:0] ld_half,
    output logic             clk_n,
    output logic             tick,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] h;
    logic             term;
    logic             hold;

    assign h    = (active == '0) ? CNT_W'(1) : active;
    assign term = (cnt == h - CNT_W'(1));

    always_comb begin
        hold = ~en;
`ifdef DIVN_SYNC_EN
        hold = ~en | sync;
`endif
    end

    // A load accept only happens while pend is clear, so it never races the apply paths.
    always_ff @(posedge click) begin
        if (reset) begin
            cnt    <= '0;
            clk_n  <= 1'b0;
            tick   <= 1'b0;
            active <= DEF_HALF;
            shadow <= DEF_HALF;
            pend   <= 1'b0;
        end else begin
            if (hold) begin
                cnt   <= '0;
                clk_n <= 1'b0;
                tick  <= 1'b0;
                if (pend) begin
                    active <= shadow;
                    pend   <= 1'b0;
                end
            end else if (term) begin
                cnt   <= '0;
                tick  <= 1'b1;
                clk_n <= (mode == MODE_PULSE) ? 1'b1 : ~clk_n;
                if (pend) begin
                    active <= shadow;
                    pend   <= 1'b0;
                end
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
                if (mode == MODE_PULSE) begin
                    clk_n <= 1'b0;
                end
            end
            if (ld_we) begin
                shadow <= ld_half;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_n.sv
// Multi-channel programmable clock divider / enable generator with handshaked divisor loads.
// Defining DIVN_SYNC_EN adds a sync input that phase-aligns all channels.
module divider_n
    import divider_n_pkg::*;
#(
    parameter int               CH       = 4,
    parameter int               CNT_W    = 32,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DIVN_DEF_HALF)
) (
    input  logic          click,
    input  logic          reset,
`ifdef DIVN_SYNC_EN
    input  logic          sync,
`endif
    input  logic [CH-1:0] en,
    input  logic [CH-1:0] mode,
    divider_n_if.slave    ld,
    output logic [CH-1:0] clk_N,
    output logic [CH-1:0] tick
);

    localparam int CHW = ch_idx_w(CH);

    logic [CH-1:0] pend;
    logic [CH-1:0] ld_we;

    // Out-of-range channel numbers match no channel and so read as not ready.
    always_comb begin
        ld.ld_ready = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (ld.ld_ch == CHW'(i)) begin
                ld.ld_ready = ~pend[i];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign ld_we[g] = ld.ld_valid & ld.ld_ready & (ld.ld_ch == CHW'(g));

        divider_n_ch #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .click   (click),
            .reset   (reset),
`ifdef DIVN_SYNC_EN
            .sync    (sync),
`endif
            .en      (en[g]),
            .mode    (mode[g]),
            .ld_we   (ld_we[g]),
            .ld_half (ld.ld_half),
            .clk_n   (clk_N[g]),
            .tick    (tick[g]),
            .pend    (pend[g])
        );
    end

endmodule
